// File: rtl/connect4_pkg.sv
// Shared types and constants for the Connect-4 turn controller slice.
package connect4_pkg;

   typedef enum logic [2:0] {
      IDLE,
      TURN_START,
      WAIT_MOVE,
      PLACE,
      CHECK,
      GAME_OVER
   } state_t;

   localparam int ROWS_DEF = 6;
   localparam int COLS_DEF = 7;

   localparam logic P1 = 1'b0;
   localparam logic P2 = 1'b1;

   localparam int ROW_W = $clog2(ROWS_DEF);
   localparam int COL_W = $clog2(COLS_DEF);
   localparam int CNT_W = $clog2(ROWS_DEF * COLS_DEF + 1);

endpackage

// File: rtl/connect4_turn_ctrl_if.sv
// Column-request and placement/win-check handshakes of the turn controller.
interface connect4_turn_ctrl_if
   import connect4_pkg::*;
#(
   parameter int ROWS = ROWS_DEF,
   parameter int COLS = COLS_DEF
);
   logic                    col_valid;
   logic [$clog2(COLS)-1:0] col_sel;
   logic                    col_ready;
   logic                    place_valid;
   logic                    place_ready;
   logic [$clog2(ROWS)-1:0] place_row;
   logic [$clog2(COLS)-1:0] place_col;
   logic                    place_player;
   logic                    check_done;
   logic                    check_win;

   modport master (
      output col_valid, col_sel, place_ready, check_done, check_win,
      input  col_ready, place_valid, place_row, place_col, place_player
   );

   modport slave (
      input  col_valid, col_sel, place_ready, check_done, check_win,
      output col_ready, place_valid, place_row, place_col, place_player
   );
endinterface

// File: rtl/connect4_col_heights.sv
// Per-column stack heights with full flags; lowest-free-column encoder
// exists only when CONNECT4_AUTOMOVE_EN is defined.
module connect4_col_heights
   import connect4_pkg::*;
#(
   parameter int ROWS = ROWS_DEF,
   parameter int COLS = COLS_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr,
   input  logic                    inc,
   input  logic [$clog2(COLS)-1:0] inc_col,
   input  logic [$clog2(COLS)-1:0] rd_col,
   output logic [$clog2(ROWS)-1:0] rd_row,
   output logic                    rd_full
`ifdef CONNECT4_AUTOMOVE_EN
   ,
   output logic [$clog2(COLS)-1:0] free_col,
   output logic [$clog2(ROWS)-1:0] free_row
`endif
);
   localparam int HW = $clog2(ROWS + 1);
   localparam int CW = $clog2(COLS);
   localparam int RW = $clog2(ROWS);

   logic [HW-1:0]   height [COLS];
   logic [COLS-1:0] full;

   always_comb begin
      for (int i = 0; i < COLS; i++) full[i] = (height[i] == HW'(ROWS));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < COLS; i++) height[i] <= '0;
      end else if (clr) begin
         for (int i = 0; i < COLS; i++) height[i] <= '0;
      end else if (inc) begin
         for (int i = 0; i < COLS; i++)
            if (inc_col == CW'(i) && !full[i]) height[i] <= height[i] + HW'(1);
      end
   end

   // Out-of-range columns read back as full so they are rejected upstream.
   always_comb begin
      rd_full = 1'b1;
      rd_row  = '0;
      for (int i = 0; i < COLS; i++) begin
         if (rd_col == CW'(i)) begin
            rd_full = full[i];
            rd_row  = RW'(height[i]);
         end
      end
   end

`ifdef CONNECT4_AUTOMOVE_EN
   always_comb begin
      free_col = '0;
      free_row = '0;
      for (int i = COLS - 1; i >= 0; i--) begin
         if (!full[i]) begin
            free_col = CW'(i);
            free_row = RW'(height[i]);
         end
      end
   end
`endif

endmodule

// File: rtl/connect4_turn_ctrl.sv
// Connect-4 turn sequencer: move intake, placement, win/draw resolution.
// Build option CONNECT4_AUTOMOVE_EN: timeout auto-places instead of forfeiting.
//
// state      | meaning
// IDLE       | after reset, waiting for start
// TURN_START | timer_rst high for one cycle
// WAIT_MOVE  | col_ready high, waiting for a column or timeout
// PLACE      | place_valid held until place_ready
// CHECK      | waiting for check_done from the win checker
// GAME_OVER  | game_over high, winner/draw valid, waiting for start
module connect4_turn_ctrl
   import connect4_pkg::*;
#(
   parameter int   ROWS         = ROWS_DEF,
   parameter int   COLS         = COLS_DEF,
   parameter logic FIRST_PLAYER = P1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start,
   input  logic                              timeout,
   output logic                              timer_rst,
   output logic                              current_player,
   output logic [$clog2(ROWS*COLS+1)-1:0]    move_count,
   output logic                              illegal_move,
   output logic                              game_over,
   output logic                              winner,
   output logic                              draw,
   connect4_turn_ctrl_if.slave               bus
);
   localparam int MCW = $clog2(ROWS * COLS + 1);
   localparam int RW  = $clog2(ROWS);

   state_t                  state;
   logic                    hgt_clr;
   logic                    hgt_inc;
   logic [RW-1:0]           rd_row;
   logic                    rd_full;
`ifdef CONNECT4_AUTOMOVE_EN
   logic [$clog2(COLS)-1:0] free_col;
   logic [RW-1:0]           free_row;
`endif

   assign hgt_clr = ((state == IDLE) || (state == GAME_OVER)) && start;
   assign hgt_inc = (state == PLACE) && bus.place_ready;

   connect4_col_heights #(.ROWS(ROWS), .COLS(COLS)) u_heights (
      .clk      (clk),
      .rst      (rst),
      .clr      (hgt_clr),
      .inc      (hgt_inc),
      .inc_col  (bus.place_col),
      .rd_col   (bus.col_sel),
      .rd_row   (rd_row),
      .rd_full  (rd_full)
`ifdef CONNECT4_AUTOMOVE_EN
      ,
      .free_col (free_col),
      .free_row (free_row)
`endif
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state            <= IDLE;
         timer_rst        <= 1'b0;
         bus.col_ready    <= 1'b0;
         bus.place_valid  <= 1'b0;
         bus.place_row    <= '0;
         bus.place_col    <= '0;
         bus.place_player <= 1'b0;
         current_player   <= FIRST_PLAYER;
         move_count       <= '0;
         illegal_move     <= 1'b0;
         game_over        <= 1'b0;
         winner           <= 1'b0;
         draw             <= 1'b0;
      end else begin
         timer_rst    <= 1'b0;
         illegal_move <= 1'b0;
         case (state)
            IDLE, GAME_OVER: begin
               if (start) begin
                  move_count     <= '0;
                  winner         <= 1'b0;
                  draw           <= 1'b0;
                  game_over      <= 1'b0;
                  current_player <= FIRST_PLAYER;
                  timer_rst      <= 1'b1;
                  state          <= TURN_START;
               end
            end
            TURN_START: begin
               bus.col_ready <= 1'b1;
               state         <= WAIT_MOVE;
            end
            WAIT_MOVE: begin
               if (bus.col_valid && !rd_full) begin
                  bus.place_row    <= rd_row;
                  bus.place_col    <= bus.col_sel;
                  bus.place_player <= current_player;
                  bus.place_valid  <= 1'b1;
                  bus.col_ready    <= 1'b0;
                  state            <= PLACE;
               end else begin
                  if (bus.col_valid) illegal_move <= 1'b1;
                  if (timeout) begin
`ifdef CONNECT4_AUTOMOVE_EN
                     bus.place_row    <= free_row;
                     bus.place_col    <= free_col;
                     bus.place_player <= current_player;
                     bus.place_valid  <= 1'b1;
                     bus.col_ready    <= 1'b0;
                     state            <= PLACE;
`else
                     current_player <= ~current_player;
                     bus.col_ready  <= 1'b0;
                     timer_rst      <= 1'b1;
                     state          <= TURN_START;
`endif
                  end
               end
            end
            PLACE: begin
               if (bus.place_ready) begin
                  bus.place_valid <= 1'b0;
                  move_count      <= move_count + MCW'(1);
                  state           <= CHECK;
               end
            end
            CHECK: begin
               if (bus.check_done) begin
                  if (bus.check_win) begin
                     winner    <= bus.place_player;
                     game_over <= 1'b1;
                     state     <= GAME_OVER;
                  end else if (move_count == MCW'(ROWS * COLS)) begin
                     draw      <= 1'b1;
                     game_over <= 1'b1;
                     state     <= GAME_OVER;
                  end else begin
                     current_player <= ~current_player;
                     timer_rst      <= 1'b1;
                     state          <= TURN_START;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
